axi_mem_arbiter: RTL and testbench
==================================

Name: axi_mem_arbiter

Overview:
Shares the single AXI-lite style sram slave between two masters. m0 is instruction fetch and issues reads only. m1 is load/store and issues reads and writes. Reads are granted round-robin, one outstanding transaction at a time, with the address registered before it goes to the slave. Writes come only from m1 and are tracked so that an m1 read never overtakes an m1 write, and vice versa.

Parameters:
DATA_LEN, 32, data bus width
STORB_LEN, 4, write-strobe width (DATA_LEN/8)
ADDR_LEN, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_arvalid/m0_raddr  in  1/ADDR_LEN  fetch read request
m0_arready  out  1  fetch request accepted
m0_rvalid/m0_rdata/m0_rresp  out  1/DATA_LEN/3  fetch read response
m0_rready  in  1  fetch response accepted
m1_arvalid/m1_raddr  in  1/ADDR_LEN; m1_arready out 1  LSU read address channel
m1_rvalid/m1_rdata/m1_rresp out 1/DATA_LEN/3; m1_rready in 1  LSU read data channel
m1_awvalid/m1_waddr in 1/ADDR_LEN; m1_awready out 1  LSU write address channel
m1_wvalid/m1_wdata/m1_wstrob in 1/DATA_LEN/STORB_LEN; m1_wready out 1  LSU write data channel
m1_bvalid/m1_bresp out 1/3; m1_bready in 1  LSU write response channel
s_arvalid/s_raddr out 1/ADDR_LEN; s_arready in 1  slave read address channel
s_rvalid/s_rdata/s_rresp in 1/DATA_LEN/3; s_rready out 1  slave read data channel
s_awvalid/s_waddr out; s_awready in  slave write address channel
s_wvalid/s_wdata/s_wstrob out; s_wready in  slave write data channel
s_bvalid/s_bresp in; s_bready out  slave write response channel

Behaviour:
- Reset (async, rst_n=0): read FSM=R_IDLE; last_grant=1, so m0 wins first; addr_reg=0; write FSM=W_IDLE; aw_done=w_done=0. All valid/ready outputs are 0 except as derived from the idle state.
- Read FSM, R_IDLE:
  - Candidates: m0_arvalid, and m1_arvalid only while the write FSM is W_IDLE and no aw/w has been accepted.
  - One candidate: grant it. Both: grant the master that is not last_grant.
  - The winner's arready is 1 combinationally in the same cycle. Latch raddr into addr_reg and the grant id, then go to R_ADDR.
  - The loser's arready is 0.
- Read FSM, R_ADDR: s_arvalid=1, s_raddr=addr_reg. On s_arready go to R_DATA.
- Read FSM, R_DATA: s_arvalid=0.
  - Route s_rvalid/s_rdata/s_rresp to the granted master; s_rready = granted master's rready.
  - The non-granted master sees rvalid=0 and rdata=0.
  - On s_rvalid&s_rready: set last_grant=grant and go to R_IDLE.
- Read latency: with a slave that has arready=1 and 1-cycle rvalid, a request accepted in cycle N gives s_arvalid in N+1 and rvalid at the master in N+2. The earliest next grant is in N+3 (the cycle after the r handshake).
- Write path:
  - m1_awready = s_awready & ~aw_done & ~m1_rd_busy, where m1_rd_busy = read FSM not idle & grant==1. m1_wready is formed the same way with w_done.
  - s_awvalid = m1_awvalid & ~aw_done & ~m1_rd_busy; s_wvalid is formed the same way. Address, data and strobe pass through.
  - aw_done and w_done set on their respective handshakes. When both are set (same cycle allowed), enter W_RESP.
  - W_RESP: forward s_bvalid/s_bresp to m1 and m1_bready to s_bready. On b handshake, clear both flags and return to W_IDLE.
- m0 reads are never blocked by writes.
- Simultaneous m0 and m1 requests in R_IDLE: round-robin as above. A master that holds arvalid across repeated rounds alternates with the other master.
- A master must not drop arvalid before arready (protocol); the arbiter does not check this.
- Reset mid-transaction: the in-flight transaction is discarded and no response is produced after reset.

Decomposition:
- Shared package holds the RRESP/BRESP OKAY=3'b000 constant and the read FSM state encodings R_IDLE/R_ADDR/R_DATA.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant register and update enable.
- The write tracker stays inline.

Test Plan:
1. Only m0_arvalid, raddr=0x8000_0000 -> m0_arready in cycle 0, s_arvalid/s_raddr=0x8000_0000 in cycle 1, m0_rvalid with slave data in cycle 2; m1 sees no activity.
2. m0 and m1 both hold arvalid from reset, addresses 0x100 and 0x200 -> grants in order m0, m1, m0, m1; each rdata is routed only to its own requester.
3. m1 aw+w to 0x300 (data 0xDEADBEEF, strobe 0xF) with m1_bready held 0 for 5 cycles, plus m1_arvalid to 0x300 -> m1_arready stays 0 until the b handshake; the read then returns 0xDEADBEEF.
4. m1 aw in cycle 0 and w in cycle 3 -> s_awvalid handshakes in cycle 0 and s_wvalid in cycle 3; W_RESP is entered only after both, and m1_bvalid is asserted once.
5. m0 read granted with m0_rready=0 for 4 cycles -> FSM stays in R_DATA, m1_arready=0 throughout, and the response is delivered when m0_rready rises.
6. rst_n pulled low during R_DATA -> all outputs 0 immediately; after release, a fresh m0 request completes normally.

Source files
------------

// File: rtl/axi_mem_arbiter_pkg.sv
// Shared constants and state encodings for the two-master sram arbiter.
package axi_mem_arbiter_pkg;

  localparam logic [2:0] RESP_OKAY = 3'b000;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

endpackage

// File: rtl/axi_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie the master that did not win last time wins.
module axi_mem_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       gnt_id,
  output logic       gnt_any
);

  logic last_grant;

  // Reset to 1 so that master 0 wins the first contested round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (upd) begin
      last_grant <= upd_id;
    end
  end

  always_comb begin
    gnt_any = |req;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI-lite sram slave between instruction fetch (m0, reads only)
// and the load/store unit (m1, reads and writes), one read outstanding at a time.
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int STORB_LEN = 4,
  parameter int ADDR_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_arvalid,
  input  logic [ADDR_LEN-1:0]  m0_raddr,
  output logic                 m0_arready,
  output logic                 m0_rvalid,
  output logic [DATA_LEN-1:0]  m0_rdata,
  output logic [2:0]           m0_rresp,
  input  logic                 m0_rready,
  input  logic                 m1_arvalid,
  input  logic [ADDR_LEN-1:0]  m1_raddr,
  output logic                 m1_arready,
  output logic                 m1_rvalid,
  output logic [DATA_LEN-1:0]  m1_rdata,
  output logic [2:0]           m1_rresp,
  input  logic                 m1_rready,
  input  logic                 m1_awvalid,
  input  logic [ADDR_LEN-1:0]  m1_waddr,
  output logic                 m1_awready,
  input  logic                 m1_wvalid,
  input  logic [DATA_LEN-1:0]  m1_wdata,
  input  logic [STORB_LEN-1:0] m1_wstrob,
  output logic                 m1_wready,
  output logic                 m1_bvalid,
  output logic [2:0]           m1_bresp,
  input  logic                 m1_bready,
  output logic                 s_arvalid,
  output logic [ADDR_LEN-1:0]  s_raddr,
  input  logic                 s_arready,
  input  logic                 s_rvalid,
  input  logic [DATA_LEN-1:0]  s_rdata,
  input  logic [2:0]           s_rresp,
  output logic                 s_rready,
  output logic                 s_awvalid,
  output logic [ADDR_LEN-1:0]  s_waddr,
  input  logic                 s_awready,
  output logic                 s_wvalid,
  output logic [DATA_LEN-1:0]  s_wdata,
  output logic [STORB_LEN-1:0] s_wstrob,
  input  logic                 s_wready,
  input  logic                 s_bvalid,
  input  logic [2:0]           s_bresp,
  output logic                 s_bready
);

  rd_state_e             rd_state, rd_next;
  logic                  grant;
  logic [ADDR_LEN-1:0]   addr_reg;
  wr_state_e             wr_state;
  logic                  aw_done, w_done;
  logic                  m1_rd_busy, wr_pending, m1_cand;
  logic                  arb_gnt, arb_any, ar_accept, r_hs;
  logic                  aw_hs, w_hs, b_hs;

  assign m1_rd_busy = (rd_state != R_IDLE) && grant;
  // A write being offered in the same cycle also holds off an m1 read, so the
  // read can never slip ahead of a store presented alongside it.
  assign wr_pending = (wr_state != W_IDLE) | aw_done | w_done | m1_awvalid | m1_wvalid;
  assign m1_cand    = m1_arvalid & ~wr_pending;
  assign ar_accept  = (rd_state == R_IDLE) & arb_any;
  assign r_hs       = (rd_state == R_DATA) & s_rvalid & s_rready;

  axi_mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1_cand, m0_arvalid}),
    .upd     (r_hs),
    .upd_id  (grant),
    .gnt_id  (arb_gnt),
    .gnt_any (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      grant    <= 1'b0;
      addr_reg <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_accept) begin
        grant    <= arb_gnt;
        addr_reg <= arb_gnt ? m1_raddr : m0_raddr;
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (arb_any) rd_next = R_ADDR;
      R_ADDR:  if (s_arready) rd_next = R_DATA;
      R_DATA:  if (s_rvalid && s_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    case (rd_state)
      R_IDLE: begin
        m0_arready = arb_any & ~arb_gnt;
        m1_arready = arb_any & arb_gnt;
      end
      R_ADDR: s_arvalid = 1'b1;
      R_DATA: begin
        if (grant) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          s_rready  = m0_rready;
        end
      end
      default: ;
    endcase
  end

  assign s_raddr = addr_reg;

  assign s_awvalid  = m1_awvalid & ~aw_done & ~m1_rd_busy;
  assign m1_awready = s_awready & ~aw_done & ~m1_rd_busy;
  assign s_wvalid   = m1_wvalid & ~w_done & ~m1_rd_busy;
  assign m1_wready  = s_wready & ~w_done & ~m1_rd_busy;
  assign s_waddr    = m1_waddr;
  assign s_wdata    = m1_wdata;
  assign s_wstrob   = m1_wstrob;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = (wr_state == W_RESP) & s_bvalid & m1_bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) wr_state <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign m1_bvalid = (wr_state == W_RESP) & s_bvalid;
  assign m1_bresp  = (wr_state == W_RESP) ? s_bresp : RESP_OKAY;
  assign s_bready  = (wr_state == W_RESP) & m1_bready;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter with a small behavioural sram slave.
module tb_axi_mem_arbiter;

  logic        clk, rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_raddr, m0_rdata;
  logic [2:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_raddr, m1_rdata;
  logic [2:0]  m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_waddr, m1_wdata;
  logic [3:0]  m1_wstrob;
  logic [2:0]  m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_raddr, s_rdata;
  logic [2:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_waddr, s_wdata;
  logic [3:0]  s_wstrob;
  logic [2:0]  s_bresp;

  int n_checks = 0;
  int n_fail   = 0;

  axi_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_raddr(m0_raddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_raddr(m1_raddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_waddr(m1_waddr), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrob(m1_wstrob), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_raddr(s_raddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_waddr(s_waddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrob(s_wstrob), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: unwritten words read back as addr ^ 0x5A5A5A5A, indexed by addr[11:8].
  logic [31:0] mem [16];
  logic        wr_flag [16];
  logic        aw_got, w_got;
  logic [31:0] waddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  wire         sl_aw_hs = s_awvalid & s_awready;
  wire         sl_w_hs  = s_wvalid & s_wready;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return wr_flag[a[11:8]] ? mem[a[11:8]] : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= 3'b000;
      s_bvalid <= 1'b0;
      s_bresp  <= 3'b000;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        wr_flag[i] <= 1'b0;
        mem[i]     <= '0;
      end
    end else begin
      if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
        s_rdata  <= '0;
      end
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_val(s_raddr);
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if ((aw_got || sl_aw_hs) && (w_got || sl_w_hs)) begin
        s_bvalid <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        mem[(aw_got ? waddr_q[11:8] : s_waddr[11:8])] <=
          merge(rd_val(aw_got ? waddr_q : s_waddr), w_got ? wdata_q : s_wdata,
                w_got ? wstrb_q : s_wstrob);
        wr_flag[(aw_got ? waddr_q[11:8] : s_waddr[11:8])] <= 1'b1;
      end else begin
        if (sl_aw_hs) begin
          aw_got  <= 1'b1;
          waddr_q <= s_waddr;
        end
        if (sl_w_hs) begin
          w_got   <= 1'b1;
          wdata_q <= s_wdata;
          wstrb_q <= s_wstrob;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_rv(input bit which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      if (which ? m1_rvalid : m0_rvalid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  typedef struct {
    logic m0v; logic [31:0] m0a; logic m1v; logic [31:0] m1a;
    logic e_m0rdy; logic e_m1rdy; logic e_sarv; logic [31:0] e_sara;
    logic e_m0rv; logic [31:0] e_m0rd; logic e_m1rv; logic [31:0] e_m1rd;
  } vec_t;

  function automatic vec_t mk(input logic m0v, input logic [31:0] m0a, input logic m1v,
                              input logic [31:0] m1a, input logic e_m0rdy, input logic e_m1rdy,
                              input logic e_sarv, input logic [31:0] e_sara,
                              input logic e_m0rv, input logic [31:0] e_m0rd,
                              input logic e_m1rv, input logic [31:0] e_m1rd);
    vec_t v;
    v.m0v = m0v; v.m0a = m0a; v.m1v = m1v; v.m1a = m1a;
    v.e_m0rdy = e_m0rdy; v.e_m1rdy = e_m1rdy; v.e_sarv = e_sarv; v.e_sara = e_sara;
    v.e_m0rv = e_m0rv; v.e_m0rd = e_m0rd; v.e_m1rv = e_m1rv; v.e_m1rd = e_m1rd;
    return v;
  endfunction

  vec_t vt [17];
  bit   ok;
  int   bcnt;

  initial begin
    // Round-robin from reset (steps 0-12), then a lone m0 fetch (13-16).
    vt[0]  = mk(1, 32'h100, 1, 32'h200, 1, 0, 0, 0,          0, 0,            0, 0);
    vt[1]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h100,    0, 0,            0, 0);
    vt[2]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 0, 0,          1, 32'h5A5A5B5A, 0, 0);
    vt[3]  = mk(1, 32'h100, 1, 32'h200, 0, 1, 0, 0,          0, 0,            0, 0);
    vt[4]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h200,    0, 0,            0, 0);
    vt[5]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 0, 0,          0, 0,            1, 32'h5A5A585A);
    vt[6]  = mk(1, 32'h100, 1, 32'h200, 1, 0, 0, 0,          0, 0,            0, 0);
    vt[7]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h100,    0, 0,            0, 0);
    vt[8]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 0, 0,          1, 32'h5A5A5B5A, 0, 0);
    vt[9]  = mk(1, 32'h100, 1, 32'h200, 0, 1, 0, 0,          0, 0,            0, 0);
    vt[10] = mk(1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h200,    0, 0,            0, 0);
    vt[11] = mk(1, 32'h100, 1, 32'h200, 0, 0, 0, 0,          0, 0,            1, 32'h5A5A585A);
    vt[12] = mk(0, 0,       0, 0,       0, 0, 0, 0,          0, 0,            0, 0);
    vt[13] = mk(1, 32'h8000_0000, 0, 0, 1, 0, 0, 0,          0, 0,            0, 0);
    vt[14] = mk(0, 0,       0, 0,       0, 0, 1, 32'h8000_0000, 0, 0,         0, 0);
    vt[15] = mk(0, 0,       0, 0,       0, 0, 0, 0,          1, 32'hDA5A5A5A, 0, 0);
    vt[16] = mk(0, 0,       0, 0,       0, 0, 0, 0,          0, 0,            0, 0);

    rst_n = 1'b0;
    m0_arvalid = 0; m0_raddr = 0; m0_rready = 1;
    m1_arvalid = 0; m1_raddr = 0; m1_rready = 1;
    m1_awvalid = 0; m1_waddr = 0; m1_wvalid = 0; m1_wdata = 0; m1_wstrob = 0; m1_bready = 0;
    s_arready = 1; s_awready = 1; s_wready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst m0_arready", 32'(m0_arready), 0);
    chk("rst s_arvalid", 32'(s_arvalid), 0);
    chk("rst s_raddr", s_raddr, 0);
    chk("rst m1_bvalid", 32'(m1_bvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      m0_arvalid = vt[i].m0v; m0_raddr = vt[i].m0a;
      m1_arvalid = vt[i].m1v; m1_raddr = vt[i].m1a;
      #1;
      chk($sformatf("v%0d m0_arready", i), 32'(m0_arready), 32'(vt[i].e_m0rdy));
      chk($sformatf("v%0d m1_arready", i), 32'(m1_arready), 32'(vt[i].e_m1rdy));
      chk($sformatf("v%0d s_arvalid", i), 32'(s_arvalid), 32'(vt[i].e_sarv));
      if (vt[i].e_sarv) chk($sformatf("v%0d s_raddr", i), s_raddr, vt[i].e_sara);
      chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vt[i].e_m0rv));
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].e_m0rd);
      chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vt[i].e_m1rv));
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].e_m1rd);
      @(negedge clk);
    end

    // Write to 0x300 held in W_RESP; an m1 read to the same word must wait.
    m1_awvalid = 1; m1_waddr = 32'h300; m1_wvalid = 1; m1_wdata = 32'hDEADBEEF;
    m1_wstrob = 4'hF; m1_bready = 0;
    #1;
    chk("wr s_awvalid", 32'(s_awvalid), 1);
    chk("wr s_wvalid", 32'(s_wvalid), 1);
    chk("wr m1_awready", 32'(m1_awready), 1);
    chk("wr m1_wready", 32'(m1_wready), 1);
    chk("wr s_waddr", s_waddr, 32'h300);
    chk("wr s_wdata", s_wdata, 32'hDEADBEEF);
    chk("wr s_wstrob", 32'(s_wstrob), 32'hF);
    @(negedge clk);
    m1_awvalid = 0; m1_wvalid = 0;
    m1_arvalid = 1; m1_raddr = 32'h300;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("wr hold%0d m1_arready", c), 32'(m1_arready), 0);
      chk($sformatf("wr hold%0d m1_bvalid", c), 32'(m1_bvalid), 1);
      chk($sformatf("wr hold%0d m1_awready", c), 32'(m1_awready), 0);
      @(negedge clk);
    end
    m1_bready = 1;
    #1;
    chk("wr b m1_bvalid", 32'(m1_bvalid), 1);
    chk("wr b s_bready", 32'(s_bready), 1);
    chk("wr b m1_bresp", 32'(m1_bresp), 0);
    chk("wr b m1_arready", 32'(m1_arready), 0);
    @(negedge clk);
    m1_bready = 0;
    #1;
    chk("wr after-b m1_arready", 32'(m1_arready), 1);
    @(negedge clk);
    m1_arvalid = 0;
    wait_rv(1'b1, ok);
    chk("rd-after-wr wait", 32'(ok), 1);
    chk("rd-after-wr m1_rdata", m1_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // aw in cycle 0, w in cycle 3: exactly one b response.
    bcnt = 0;
    m1_bready = 1;
    for (int c = 0; c < 9; c++) begin
      m1_awvalid = (c == 0); m1_waddr = 32'h400;
      m1_wvalid = (c == 3); m1_wdata = 32'h12345678; m1_wstrob = 4'h3;
      #1;
      if (c == 0) begin
        chk("split c0 s_awvalid", 32'(s_awvalid), 1);
        chk("split c0 m1_awready", 32'(m1_awready), 1);
        chk("split c0 s_wvalid", 32'(s_wvalid), 0);
      end
      if (c == 1) chk("split c1 m1_awready", 32'(m1_awready), 0);
      if (c == 1 || c == 2) chk($sformatf("split c%0d m1_bvalid", c), 32'(m1_bvalid), 0);
      if (c == 3) begin
        chk("split c3 s_wvalid", 32'(s_wvalid), 1);
        chk("split c3 m1_wready", 32'(m1_wready), 1);
        chk("split c3 s_wstrob", 32'(s_wstrob), 32'h3);
        chk("split c3 m1_bvalid", 32'(m1_bvalid), 0);
      end
      if (c == 4) chk("split c4 m1_bvalid", 32'(m1_bvalid), 1);
      if (m1_bvalid) bcnt++;
      @(negedge clk);
    end
    chk("split bvalid count", 32'(bcnt), 1);
    m1_bready = 0;

    // m0 response stalled by m0_rready=0 while m1 keeps requesting.
    m0_arvalid = 1; m0_raddr = 32'h500; m1_arvalid = 1; m1_raddr = 32'h600; m0_rready = 0;
    #1;
    chk("stall c0 m0_arready", 32'(m0_arready), 1);
    chk("stall c0 m1_arready", 32'(m1_arready), 0);
    @(negedge clk);
    m0_arvalid = 0;
    #1;
    chk("stall c1 s_arvalid", 32'(s_arvalid), 1);
    chk("stall c1 m1_arready", 32'(m1_arready), 0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stall w%0d m0_rvalid", c), 32'(m0_rvalid), 1);
      chk($sformatf("stall w%0d s_rready", c), 32'(s_rready), 0);
      chk($sformatf("stall w%0d m1_arready", c), 32'(m1_arready), 0);
      chk($sformatf("stall w%0d m0_rdata", c), m0_rdata, 32'h5A5A5F5A);
      @(negedge clk);
    end
    m0_rready = 1;
    #1;
    chk("stall rel m0_rvalid", 32'(m0_rvalid), 1);
    chk("stall rel s_rready", 32'(s_rready), 1);
    chk("stall rel m1_arready", 32'(m1_arready), 0);
    @(negedge clk);
    #1;
    chk("stall next m1_arready", 32'(m1_arready), 1);
    chk("stall next m0_rvalid", 32'(m0_rvalid), 0);
    @(negedge clk);
    m1_arvalid = 0;
    wait_rv(1'b1, ok);
    chk("stall m1 wait", 32'(ok), 1);
    chk("stall m1_rdata", m1_rdata, 32'h5A5A5C5A);
    @(negedge clk);

    // Reset while sitting in R_DATA.
    m0_arvalid = 1; m0_raddr = 32'h700; m0_rready = 0;
    @(negedge clk);
    m0_arvalid = 0;
    @(negedge clk);
    #1;
    chk("rstmid pre m0_rvalid", 32'(m0_rvalid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid m0_rvalid", 32'(m0_rvalid), 0);
    chk("rstmid m0_rdata", m0_rdata, 0);
    chk("rstmid s_arvalid", 32'(s_arvalid), 0);
    chk("rstmid s_rready", 32'(s_rready), 0);
    chk("rstmid s_raddr", s_raddr, 0);
    chk("rstmid m0_arready", 32'(m0_arready), 0);
    chk("rstmid m1_bvalid", 32'(m1_bvalid), 0);
    m0_rready = 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rstmid quiet%0d m0_rvalid", c), 32'(m0_rvalid), 0);
      @(negedge clk);
    end
    m0_arvalid = 1; m0_raddr = 32'h800;
    #1;
    chk("rstmid fresh m0_arready", 32'(m0_arready), 1);
    @(negedge clk);
    m0_arvalid = 0;
    wait_rv(1'b0, ok);
    chk("rstmid fresh wait", 32'(ok), 1);
    chk("rstmid fresh m0_rdata", m0_rdata, 32'h5A5A525A);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
